weight_load_ctrl: RTL and testbench
===================================

# weight_load_ctrl

Streams CNN weights from the upstream DMA/bus port into the local weight buffer, one layer at a time. Accepts 16-bit weights over a valid/ready handshake, tags each with the current layer code, and emits the registered write strobe, data, address, `weight_fsm_cs` and `weight_store_done` that the local weight memory consumes. Sits directly upstream of the local weight buffer. Pauses after each layer until the compute controller requests the next one.

## Interface
Parameters:
- `L1_CNT`, default 216: layer-1 element count (8 filters × 9 taps × 3 channels).
- `L8_CNT`, default 576: element count for layers 2, 4 and 5 (72 words × 8 channels).
- `L7_CNT`, default 400: layer-7 element count (50 words × 8 channels).

Ports:
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: synchronous, active-low reset.
- `start`  input  1: begin a load sequence; honoured only in IDLE or FINISH.
- `in_valid`  input  1: upstream weight valid.
- `in_data`  input  16: upstream weight.
- `in_ready`  output  1: block can accept a weight.
- `next_layer`  input  1: compute controller releases the buffer for the next layer; honoured only while `hold`=1.
- `write_weight_signal`  output  1: one-cycle write strobe per element.
- `write_weight_data`  output  16: element being written.
- `write_weight_addr`  output  16: element index within the current layer.
- `weight_fsm_cs`  output  4: current layer code.
- `weight_store_done`  output  1: current layer fully written and waiting for release, or the sequence is finished.

## Operation
- Layer codes: IDLE=4'b0000, L1=4'b0001, L2=4'b0010, L4=4'b0011, L5=4'b0100, L7=4'b0101, FINISH=4'b1111.
- `weight_fsm_cs` is the state register itself.
- Sequence: IDLE →(`start`) L1 → L2 → L4 → L5 → L7 → FINISH →(`start`) L1.
- In FINISH, `start` restarts the sequence at L1.
- `start` is ignored in every other state.
- Target count per state:
  - L1: `L1_CNT`.
  - L2, L4, L5: `L8_CNT`.
  - L7: `L7_CNT`.
- `in_ready` = (state ∈ {L1, L2, L4, L5, L7}) && !`hold`. It is decoded from registers only.
- A transfer occurs when `in_valid` && `in_ready`. On each transfer, `idx` (16 bit) increments.
- On the transfer where `idx` == target−1:
  - `idx` returns to 0.
  - `hold` is set on the next edge.
- `hold`=1 with `next_layer`=1:
  - State advances to the next layer code.
  - `hold` clears.
  - `idx` stays 0.
- After L7 the advance goes to FINISH, which holds with `in_ready`=0.
- `next_layer` while `hold`=0 is ignored.
- `weight_store_done` = `hold` || (state==FINISH).
- Arithmetic: `idx` is unsigned 16-bit. Targets must be ≥1 and multiples of 3 (L1) or 8 (other layers); the downstream channel packer relies on this.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, `hold`=0, `idx`=0. All outputs are 0: `in_ready`, `write_weight_signal`, `write_weight_data`, `write_weight_addr`, `weight_fsm_cs`, `weight_store_done`.
- Reset mid-layer discards the partial layer. No write strobe follows the reset edge.
- Write latency is 1 cycle. The edge that completes a transfer registers:
  - `write_weight_signal`=1.
  - `write_weight_data`=`in_data`.
  - `write_weight_addr`=pre-increment `idx`.
- Without a transfer, `write_weight_signal`=0 and data/addr hold their last values.
- `weight_fsm_cs` seen alongside a write strobe is always the layer that element belongs to. The final write of a layer coincides with the first `hold`=1 cycle. A `next_layer` sampled then changes state only on the following edge.
- `in_ready` drops the cycle after the last transfer of a layer, so there is no over-acceptance.
- `next_layer` and `in_valid` high together during `hold`: only the advance happens. `in_ready` rises the cycle after the advance.
- Back-to-back transfers are sustained at 1 element/cycle within a layer.
- `start` together with `next_layer` in FINISH: `start` wins and state goes to L1.

## Structure
- Shared package `cnn_weight_pkg` holds the 4-bit layer-code constants. It is shared with the local weight buffer.
- The count parameters are module parameters, not package constants.
- Single flat module: one state register, the `hold` flag, the `idx` counter and the output registers. No sub-module.

## Test plan
- Reset then `start`, stream 216 weights 0x0001..0x00D8 with `in_valid` held high:
  - 216 strobes, addr 0..215, `weight_fsm_cs`=1 on each.
  - `weight_store_done`=1 from the cycle of the write to addr 215.
  - `in_ready`=0 from the next cycle.
- Full sequence with `next_layer` pulsed at each hold: write counts 216/576/576/576/400 with cs 1/2/3/4/5, then cs=F and `weight_store_done`=1 stuck.
- Random `in_valid` gaps of 0–5 cycles in L2: data and addr order are preserved, no strobe without a transfer, and 576 writes in total.
- `next_layer` pulsed mid-L4 at addr 100, then `next_layer` and `in_valid` high together at hold: the early pulse is ignored, the state advances once, and the first L5 write lands at addr 0 one cycle after `in_ready` rises.
- `rst`=0 at L5 addr 300: the next cycle shows all outputs 0 and cs=0. `start` then reloads from L1 at addr 0.
- In FINISH, `start`=1: cs=1 on the next edge and `in_ready`=1. `start` asserted during L2 has no effect.

Source files
------------

// File: rtl/cnn_weight_pkg.sv
// Layer codes shared by the weight-load controller and the local weight buffer.
// The buffer decodes weight_fsm_cs against these same values.
package cnn_weight_pkg;

    typedef enum logic [3:0] {
        LAYER_IDLE   = 4'b0000,
        LAYER_L1     = 4'b0001,
        LAYER_L2     = 4'b0010,
        LAYER_L4     = 4'b0011,
        LAYER_L5     = 4'b0100,
        LAYER_L7     = 4'b0101,
        LAYER_FINISH = 4'b1111
    } layer_e;

    // True for the layers that actually stream weights into the buffer.
    function automatic logic is_load_layer(input layer_e code);
        logic res;
        case (code)
            LAYER_L1, LAYER_L2, LAYER_L4, LAYER_L5, LAYER_L7: res = 1'b1;
            default:                                          res = 1'b0;
        endcase
        return res;
    endfunction

    // Layer that follows a completed layer; anything unexpected parks in FINISH.
    function automatic layer_e layer_after(input layer_e code);
        layer_e res;
        case (code)
            LAYER_L1: res = LAYER_L2;
            LAYER_L2: res = LAYER_L4;
            LAYER_L4: res = LAYER_L5;
            LAYER_L5: res = LAYER_L7;
            LAYER_L7: res = LAYER_FINISH;
            default:  res = LAYER_FINISH;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/weight_load_ctrl.sv
// Streams 16-bit CNN weights into the local weight buffer one layer at a time,
// pausing after each layer until the compute controller releases the buffer.
module weight_load_ctrl
    import cnn_weight_pkg::*;
#(
    parameter int unsigned L1_CNT = 32'd216,
    parameter int unsigned L8_CNT = 32'd576,
    parameter int unsigned L7_CNT = 32'd400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        next_layer,
    output logic        write_weight_signal,
    output logic [15:0] write_weight_data,
    output logic [15:0] write_weight_addr,
    output logic [3:0]  weight_fsm_cs,
    output logic        weight_store_done
);

    localparam logic [15:0] L1_TGT = 16'(L1_CNT);
    localparam logic [15:0] L8_TGT = 16'(L8_CNT);
    localparam logic [15:0] L7_TGT = 16'(L7_CNT);

    layer_e      state_r;
    layer_e      state_nx_s;
    logic        hold_r;
    logic        hold_nx_s;
    logic [15:0] idx_r;
    logic [15:0] idx_nx_s;
    logic [15:0] target_s;
    logic        ready_s;
    logic        xfer_s;
    logic        last_s;
    logic        wr_sig_r;
    logic [15:0] wr_data_r;
    logic [15:0] wr_addr_r;

    // Element count of the layer currently being loaded.
    always_comb begin
        target_s = 16'd0;
        case (state_r)
            LAYER_L1:                     target_s = L1_TGT;
            LAYER_L2, LAYER_L4, LAYER_L5: target_s = L8_TGT;
            LAYER_L7:                     target_s = L7_TGT;
            default:                      target_s = 16'd0;
        endcase
    end

    assign ready_s = is_load_layer(state_r) && !hold_r;
    assign xfer_s  = in_valid && ready_s;
    assign last_s  = (idx_r == (target_s - 16'd1));

    // Layer sequencing, end-of-layer hold and element index.
    always_comb begin
        state_nx_s = state_r;
        hold_nx_s  = hold_r;
        idx_nx_s   = idx_r;
        case (state_r)
            LAYER_IDLE, LAYER_FINISH: begin
                if (start) begin
                    state_nx_s = LAYER_L1;
                    hold_nx_s  = 1'b0;
                    idx_nx_s   = 16'd0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            LAYER_L1, LAYER_L2, LAYER_L4, LAYER_L5, LAYER_L7: begin
                if (hold_r) begin
                    // While held, the only way forward is the release; in_valid is not accepted.
                    if (next_layer) begin
                        state_nx_s = layer_after(state_r);
                        hold_nx_s  = 1'b0;
                        idx_nx_s   = 16'd0;
                    end else begin
                        hold_nx_s = 1'b1;
                    end
                end else if (xfer_s) begin
                    if (last_s) begin
                        idx_nx_s  = 16'd0;
                        hold_nx_s = 1'b1;
                    end else begin
                        idx_nx_s = idx_r + 16'd1;
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            default: begin
                state_nx_s = LAYER_IDLE;
                hold_nx_s  = 1'b0;
                idx_nx_s   = 16'd0;
            end
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= LAYER_IDLE;
            hold_r  <= 1'b0;
            idx_r   <= 16'd0;
        end else begin
            state_r <= state_nx_s;
            hold_r  <= hold_nx_s;
            idx_r   <= idx_nx_s;
        end
    end

    // Write port registers: strobe for one cycle per accepted weight, data/addr hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_sig_r  <= 1'b0;
            wr_data_r <= 16'd0;
            wr_addr_r <= 16'd0;
        end else if (xfer_s) begin
            wr_sig_r  <= 1'b1;
            wr_data_r <= in_data;
            wr_addr_r <= idx_r;
        end else begin
            wr_sig_r  <= 1'b0;
        end
    end

    assign in_ready            = ready_s;
    assign write_weight_signal = wr_sig_r;
    assign write_weight_data   = wr_data_r;
    assign write_weight_addr   = wr_addr_r;
    assign weight_fsm_cs       = state_r;
    assign weight_store_done   = hold_r || (state_r == LAYER_FINISH);

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: vector table for reset/start behaviour, then
// randomized layer streaming checked cycle by cycle against a layer-level model.
module tb_weight_load_ctrl;

    localparam int L1_N = 216;
    localparam int L8_N = 576;
    localparam int L7_N = 400;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        next_layer;
    logic        write_weight_signal;
    logic [15:0] write_weight_data;
    logic [15:0] write_weight_addr;
    logic [3:0]  weight_fsm_cs;
    logic        weight_store_done;

    int checks   = 0;
    int failures = 0;

    weight_load_ctrl #(.L1_CNT(L1_N), .L8_CNT(L8_N), .L7_CNT(L7_N)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .next_layer          (next_layer),
        .write_weight_signal (write_weight_signal),
        .write_weight_data   (write_weight_data),
        .write_weight_addr   (write_weight_addr),
        .weight_fsm_cs       (weight_fsm_cs),
        .weight_store_done   (weight_store_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: position in the layer list (0 idle, 1..5 loading layers, 6 finished),
    // elements written so far in the layer, and whether the layer awaits release.
    int          m_pos  = 0;
    bit          m_wait = 1'b0;
    int          m_cnt  = 0;
    bit          m_ws   = 1'b0;
    logic [15:0] m_wd   = 16'd0;
    logic [15:0] m_wa   = 16'd0;

    function automatic int code_of(input int pos);
        int codes[7] = '{0, 1, 2, 3, 4, 5, 15};
        return codes[pos];
    endfunction

    function automatic int count_of(input int pos);
        int cnts[7] = '{0, L1_N, L8_N, L8_N, L8_N, L7_N, 0};
        return cnts[pos];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model and DUT, compare every output.
    task automatic cyc(input logic r, input logic s, input logic v, input logic [15:0] d, input logic nl);
        bit loading;
        rst = r; start = s; in_valid = v; in_data = d; next_layer = nl;
        loading = (m_pos >= 1) && (m_pos <= 5);
        @(posedge clk);
        if (!r) begin
            m_pos = 0; m_wait = 1'b0; m_cnt = 0; m_ws = 1'b0; m_wd = 16'd0; m_wa = 16'd0;
        end else begin
            m_ws = 1'b0;
            if ((m_pos == 0 || m_pos == 6) && s) begin
                m_pos = 1; m_wait = 1'b0; m_cnt = 0;
            end else if (loading && m_wait) begin
                if (nl) begin
                    m_pos++; m_wait = 1'b0; m_cnt = 0;
                end
            end else if (loading && v) begin
                m_ws = 1'b1; m_wd = d; m_wa = 16'(m_cnt);
                m_cnt++;
                if (m_cnt == count_of(m_pos)) begin
                    m_cnt = 0; m_wait = 1'b1;
                end
            end
        end
        #1;
        chk("ready",  int'(in_ready), int'((m_pos >= 1) && (m_pos <= 5) && !m_wait));
        chk("wsig",   int'(write_weight_signal), int'(m_ws));
        chk("wdata",  int'(write_weight_data), int'(m_wd));
        chk("waddr",  int'(write_weight_addr), int'(m_wa));
        chk("cs",     int'(weight_fsm_cs), code_of(m_pos));
        chk("done",   int'(weight_store_done), int'(m_wait || m_pos == 6));
    endtask

    // Feed random weights with 0..gap_max idle cycles between them until the layer
    // completes (or stop_cnt elements are written when stop_cnt > 0).
    task automatic stream(input int gap_max, input int stop_cnt, input bit rand_start, output int writes);
        int budget;
        budget = 4000;
        writes = 0;
        while (!m_wait && !(stop_cnt > 0 && m_cnt == stop_cnt) && budget > 0) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int i = 0; i < g; i++) begin
                cyc(1'b1, rand_start && ($urandom_range(3, 0) == 0), 1'b0, 16'($urandom), 1'b0);
                writes += int'(write_weight_signal);
                budget--;
            end
            cyc(1'b1, rand_start && ($urandom_range(3, 0) == 0), 1'b1, 16'($urandom), 1'b0);
            writes += int'(write_weight_signal);
            budget--;
        end
        chk("stream_budget", int'(budget > 0), 1);
    endtask

    typedef struct {
        logic        rst;
        logic        start;
        logic        vld;
        logic [15:0] data;
        logic        nl;
        logic        rdy;
        logic        ws;
        logic [15:0] wd;
        logic [15:0] wa;
        logic [3:0]  cs;
        logic        done;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   n;
        int   n2;
        int   exp_cnt[5] = '{L1_N, L8_N, L8_N, L8_N, L7_N};

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 16'd0; next_layer = 1'b0;

        //         rst   start vld   data       nl    rdy   ws    wd         wa      cs    done
        tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 4'h0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 4'h0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 4'h1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0001, 16'd0, 4'h1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h0001, 16'd0, 4'h1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0002, 16'd1, 4'h1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 4'h0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].rst, tbl[i].start, tbl[i].vld, tbl[i].data, tbl[i].nl);
            chk($sformatf("vec%0d_ready", i), int'(in_ready), int'(tbl[i].rdy));
            chk($sformatf("vec%0d_wsig", i),  int'(write_weight_signal), int'(tbl[i].ws));
            chk($sformatf("vec%0d_wdata", i), int'(write_weight_data), int'(tbl[i].wd));
            chk($sformatf("vec%0d_waddr", i), int'(write_weight_addr), int'(tbl[i].wa));
            chk($sformatf("vec%0d_cs", i),    int'(weight_fsm_cs), int'(tbl[i].cs));
            chk($sformatf("vec%0d_done", i),  int'(weight_store_done), int'(tbl[i].done));
        end

        // Layer 1 with in_valid held high and data 0x0001..0x00D8.
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        n = 0;
        for (int k = 0; k < 300 && !m_wait; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 16'(k + 1), 1'b0);
            if (write_weight_signal && weight_fsm_cs == 4'h1) n++;
            if (write_weight_signal && write_weight_addr == 16'd215) begin
                chk("l1_done_at_215", int'(weight_store_done), 1);
                chk("l1_last_data", int'(write_weight_data), 16'h00D8);
            end
        end
        chk("l1_writes", n, L1_N);
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        chk("l1_ready_low", int'(in_ready), 0);
        chk("l1_no_extra", int'(write_weight_signal), 0);

        // Release into L2; start during L2 is ignored; random gaps.
        cyc(1'b1, 1'b0, 1'b1, 16'h5555, 1'b1);
        chk("l2_cs", int'(weight_fsm_cs), 2);
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        chk("l2_start_ignored", int'(weight_fsm_cs), 2);
        stream(5, 0, 1'b1, n);
        chk("l2_writes", n, L8_N);

        // L4: early next_layer at addr 100 is ignored; release coincides with in_valid.
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        chk("l4_cs", int'(weight_fsm_cs), 3);
        stream(0, 101, 1'b0, n);
        chk("l4_at_100", int'(write_weight_addr), 100);
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        chk("l4_early_nl_cs", int'(weight_fsm_cs), 3);
        chk("l4_early_nl_done", int'(weight_store_done), 0);
        stream(0, 0, 1'b0, n2);
        chk("l4_writes", n + n2, L8_N);
        cyc(1'b1, 1'b0, 1'b1, 16'h7777, 1'b1);
        chk("l5_adv_cs", int'(weight_fsm_cs), 4);
        chk("l5_adv_nowrite", int'(write_weight_signal), 0);
        chk("l5_adv_ready", int'(in_ready), 1);
        cyc(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        chk("l5_first_wsig", int'(write_weight_signal), 1);
        chk("l5_first_addr", int'(write_weight_addr), 0);
        chk("l5_first_data", int'(write_weight_data), 16'hBEEF);

        // Reset in the middle of L5.
        stream(2, 301, 1'b0, n);
        chk("l5_at_300", int'(write_weight_addr), 300);
        cyc(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_wsig", int'(write_weight_signal), 0);
        chk("rst_wdata", int'(write_weight_data), 0);
        chk("rst_waddr", int'(write_weight_addr), 0);
        chk("rst_cs", int'(weight_fsm_cs), 0);
        chk("rst_done", int'(weight_store_done), 0);

        // Full sequence after reload.
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        chk("reload_cs", int'(weight_fsm_cs), 1);
        for (int l = 0; l < 5; l++) begin
            stream(3, 0, 1'b0, n);
            chk($sformatf("seq_writes_l%0d", l), n, exp_cnt[l]);
            cyc(1'b1, 1'b0, 1'b1, 16'h0F0F, 1'b1);
        end
        chk("finish_cs", int'(weight_fsm_cs), 15);
        chk("finish_done", int'(weight_store_done), 1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 16'h2222, 1'b1);
            chk("finish_stuck_cs", int'(weight_fsm_cs), 15);
            chk("finish_stuck_ready", int'(in_ready), 0);
            chk("finish_stuck_done", int'(weight_store_done), 1);
        end

        // start beats next_layer in FINISH.
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 1'b1);
        chk("restart_cs", int'(weight_fsm_cs), 1);
        chk("restart_ready", int'(in_ready), 1);
        chk("restart_done", int'(weight_store_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
